// File: rtl/sevenseg_scan_driver.sv
// sevenseg_scan_driver
//   Scans a 4-digit multiplexed seven-segment display. A free-running slot
//   counter selects one digit at a time (digit 0 = rightmost). The block
//   decodes that digit's nibble to segments, applies brightness PWM,
//   leading-zero blanking and forced blanking, and registers an/seg/seg_dp
//   together. New data is staged in pending registers and swapped into the
//   display registers only at a frame boundary, so a frame never mixes old
//   and new data.
//
// Parameters
//   REFRESH_BITS   slot counter width; one digit slot is 2^REFRESH_BITS cycles (>= 4)
//   SEG_ACTIVE_LOW 1: seg/seg_dp drive 0 to light a segment
//   AN_ACTIVE_LOW  1: an drives 0 to enable a digit
//
// Ports
//   CLK        system clock
//   nrst       synchronous active-low reset
//   value      16-bit hex value, nibble k -> digit k
//   dp         per-digit decimal point request
//   blank      per-digit forced blank
//   lz_blank   enable leading-zero blanking
//   bright     brightness 0 (1/8 duty) .. 7 (full), used live
//   load       strobe capturing value/dp/blank/lz_blank
//   seg        segments {g,f,e,d,c,b,a}
//   seg_dp     decimal-point segment
//   an         digit enables, an[k] for digit k
//   frame_tick one-cycle pulse at the start of each frame
module sevenseg_scan_driver #(
  parameter int REFRESH_BITS   = 16,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic        CLK,
  input  logic        nrst,
  input  logic [15:0] value,
  input  logic [3:0]  dp,
  input  logic [3:0]  blank,
  input  logic        lz_blank,
  input  logic [2:0]  bright,
  input  logic        load,
  output logic [6:0]  seg,
  output logic        seg_dp,
  output logic [3:0]  an,
  output logic        frame_tick
);

  localparam logic [REFRESH_BITS-1:0] CNT_ONE = {{(REFRESH_BITS-1){1'b0}}, 1'b1};

  // Physical levels for an unlit digit
  localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic       DP_OFF  = SEG_ACTIVE_LOW ? 1'b1  : 1'b0;
  localparam logic [3:0] AN_OFF  = AN_ACTIVE_LOW  ? 4'hF  : 4'h0;

  logic [REFRESH_BITS-1:0] cnt;
  logic [1:0]              idx;

  logic [15:0] pend_value;
  logic [3:0]  pend_dp;
  logic [3:0]  pend_blank;
  logic        pend_lz;
  logic        pend_valid;

  logic [15:0] disp_value;
  logic [3:0]  disp_dp;
  logic [3:0]  disp_blank;
  logic        disp_lz;

  logic        slot_end;
  logic        frame_wrap;

  assign slot_end   = &cnt;
  assign frame_wrap = slot_end && (idx == 2'd3);

  // Slot counter, digit index and frame pulse
  always_ff @(posedge CLK) begin
    if (!nrst) begin
      cnt        <= '0;
      idx        <= 2'd0;
      frame_tick <= 1'b0;
    end else begin
      cnt        <= cnt + CNT_ONE;
      frame_tick <= frame_wrap;
      if (slot_end) begin
        idx <= idx + 2'd1;
      end
    end
  end

  // Pending / display staging. A load landing on the wrap cycle goes straight
  // to the display registers so it is not delayed by a whole frame.
  always_ff @(posedge CLK) begin
    if (!nrst) begin
      pend_value <= '0;
      pend_dp    <= '0;
      pend_blank <= '0;
      pend_lz    <= 1'b0;
      pend_valid <= 1'b0;
      disp_value <= '0;
      disp_dp    <= '0;
      disp_blank <= '0;
      disp_lz    <= 1'b0;
    end else begin
      if (load) begin
        pend_value <= value;
        pend_dp    <= dp;
        pend_blank <= blank;
        pend_lz    <= lz_blank;
      end
      if (frame_wrap && load) begin
        disp_value <= value;
        disp_dp    <= dp;
        disp_blank <= blank;
        disp_lz    <= lz_blank;
        pend_valid <= 1'b0;
      end else if (frame_wrap && pend_valid) begin
        disp_value <= pend_value;
        disp_dp    <= pend_dp;
        disp_blank <= pend_blank;
        disp_lz    <= pend_lz;
        pend_valid <= 1'b0;
      end else if (load) begin
        pend_valid <= 1'b1;
      end
    end
  end

  // Active-high gfedcba pattern for a hex nibble
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  logic [3:0] cur_nib;
  logic [3:0] lz_mask;
  logic       pwm_on;
  logic       digit_on;
  logic [6:0] seg_lit;
  logic       dp_lit;
  logic [3:0] an_lit;
  logic [6:0] seg_nxt;
  logic       dp_nxt;
  logic [3:0] an_nxt;

  always_comb begin
    cur_nib = 4'h0;
    case (idx)
      2'd0:    cur_nib = disp_value[3:0];
      2'd1:    cur_nib = disp_value[7:4];
      2'd2:    cur_nib = disp_value[11:8];
      default: cur_nib = disp_value[15:12];
    endcase
  end

  // A digit is a leading zero when it and every more significant nibble are
  // zero; digit 0 always shows so an all-zero value still reads "0".
  always_comb begin
    lz_mask    = 4'b0000;
    lz_mask[3] = disp_lz && (disp_value[15:12] == 4'h0);
    lz_mask[2] = lz_mask[3] && (disp_value[11:8] == 4'h0);
    lz_mask[1] = lz_mask[2] && (disp_value[7:4] == 4'h0);
  end

  always_comb begin
    pwm_on   = (cnt[REFRESH_BITS-1 -: 3] <= bright);
    digit_on = pwm_on && !disp_blank[idx];
    seg_lit  = 7'h00;
    dp_lit   = 1'b0;
    an_lit   = 4'b0000;
    if (digit_on) begin
      an_lit = 4'b0001 << idx;
      dp_lit = disp_dp[idx];
      if (!lz_mask[idx]) begin
        seg_lit = hex_to_seg(cur_nib);
      end
    end
    seg_nxt = SEG_ACTIVE_LOW ? ~seg_lit : seg_lit;
    dp_nxt  = SEG_ACTIVE_LOW ? ~dp_lit  : dp_lit;
    an_nxt  = AN_ACTIVE_LOW  ? ~an_lit  : an_lit;
  end

  // Anode and segments update on the same edge to avoid ghosting
  always_ff @(posedge CLK) begin
    if (!nrst) begin
      seg    <= SEG_OFF;
      seg_dp <= DP_OFF;
      an     <= AN_OFF;
    end else begin
      seg    <= seg_nxt;
      seg_dp <= dp_nxt;
      an     <= an_nxt;
    end
  end

endmodule

// File: doc/sevenseg_scan_driver.md
Name: sevenseg_scan_driver

Overview:
Output-side counterpart to the board's button debouncer: drives the 4-digit multiplexed common-anode seven-segment display on the 50 MHz board. Core/debug logic loads a 16-bit hex value with per-digit decimal points and blanks. The block time-multiplexes the anodes, decodes nibbles to segments, applies brightness PWM and leading-zero blanking, and swaps new data in only at frame boundaries so the display never tears.

Parameters:
REFRESH_BITS, 16, width of the free-running slot counter; each digit slot lasts 2^REFRESH_BITS cycles (≈1.31 ms at 50 MHz). Minimum 4.
SEG_ACTIVE_LOW, 1, 1 means seg and seg_dp drive 0 to light a segment.
AN_ACTIVE_LOW, 1, 1 means an drives 0 to enable a digit.

Ports:
CLK  in  1  system clock, 50 MHz
nrst  in  1  synchronous active-low reset
value  in  16  hex value; nibble k drives digit k, and digit 0 is the rightmost
dp  in  4  per-digit decimal point request
blank  in  4  per-digit forced blank
lz_blank  in  1  enable leading-zero blanking
bright  in  3  brightness level, 0 (1/8 duty) to 7 (full)
load  in  1  single-cycle strobe that captures value, dp, blank and lz_blank
seg  out  7  segments {g,f,e,d,c,b,a}, seg[0]=a
seg_dp  out  1  decimal-point segment
an  out  4  digit enables, an[k] for digit k
frame_tick  out  1  one-cycle pulse at the start of each frame

Behaviour:
- Reset is synchronous and active-low on CLK. Everything is cleared: slot counter cnt=0, digit index idx=0, all pending and display registers 0, pend_valid=0, frame_tick=0.
- Outputs during reset are "all off": an all inactive, seg all unlit, seg_dp unlit. With default parameters this means an=4'hF, seg=7'h7F, seg_dp=1.
- Assertion of nrst mid-operation takes effect at the next edge. No partial frame survives.
- Counter: cnt increments every cycle and wraps. "Slot end" means cnt is all-ones; at slot end idx advances mod 4 in the order 0→1→2→3→0.
- Frame wrap: slot end while idx==3.
- Load capture: load=1 captures {value, dp, blank, lz_blank} into pending registers and sets pend_valid. Repeated loads inside one frame overwrite; the last one wins. bright is not captured; it is sampled live.
- Frame transfer: on a frame-wrap cycle with pend_valid=1, pending moves to the display registers and pend_valid clears.
- Load on a frame-wrap cycle: the new inputs go straight to the display registers, bypassing pending, and pend_valid ends at 0.
- frame_tick is registered. It is high exactly in the cycle where idx==0 and cnt==0 after a wrap, every frame, whether or not a transfer happened.
- Decode (active-high gfedcba): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71. With SEG_ACTIVE_LOW=1 the pattern is inverted.
- Leading-zero blanking: applies when the displayed lz_blank=1. Digit k (k≥1) is lz-blanked if nibble k and every higher nibble are zero. Digit 0 is never lz-blanked, so 0x0000 shows "0".
  - An lz-blanked digit has its anode on and segments off, but still shows its dp.
- Forced blank: blank[k]=1 turns off digit k's anode, segments and dp.
- PWM: the digit is enabled when cnt[REFRESH_BITS-1 -: 3] <= bright. bright=7 gives 100% duty; bright=0 lights only the first 1/8 of the slot.
- Output latency: an, seg and seg_dp are registered together, one cycle after the cnt/idx state they reflect. All three change on the same edge, which prevents ghosting.
- Only one anode is ever active at a time. No other combination is legal.

Test Plan:
1. Reset/idle: hold nrst=0 for 3 cycles, then release with no load → an=4'hF, seg=7'h7F and seg_dp=1 throughout. frame_tick first pulses after 4·2^REFRESH_BITS cycles.
2. Basic scan (REFRESH_BITS=4): load value=16'h12AF, bright=7, all other fields 0, then wait for frame_tick.
   - The following frame shows an=1110/seg=0x0E, then 1101/0x08, then 1011/0x24, then 0111/0x79.
   - Each slot is 16 cycles with seg_dp=1.
3. Leading-zero blanking: load 16'h0040 with lz_blank=1 → digits 3 and 2 show seg=0x7F, digit 1 shows 0x19, digit 0 shows 0x40. Then load 16'h0000 → only digit 0 shows 0x40.
4. Brightness (REFRESH_BITS=6, bright=0): each 64-cycle slot has its anode active for cycles 0–7 only (offset by the 1-cycle latency). Setting bright=3 gives 32 active cycles.
5. Load timing:
   - Two loads mid-frame (0x1111, then 0x2222) → display stays unchanged until frame_tick, then shows 2222.
   - A load asserted on the wrap cycle takes effect in the frame starting at the next cycle.
   - dp=4'b0100 with blank=4'b0100 → seg_dp stays 1 and an[2] stays inactive.
6. Reset mid-scan: drop nrst while idx=2 → next edge gives an=4'hF and seg=7'h7F. After release, the display registers are 0, the digits show "0000", and scanning restarts at digit 0.
